// File: rtl/axis_packet_arbiter_if.sv
// AXI-Stream bundle for the packet arbiter: N_SRC slave-side sources in, one master stream out.
// The master modport is the arbiter's view; slave is the view of the surrounding sources/sink.
interface axis_packet_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 32
);
  logic [N_SRC-1:0]        s_tvalid;
  logic [N_SRC-1:0]        s_tready;
  logic [N_SRC*DATA_W-1:0] s_tdata;
  logic [N_SRC-1:0]        s_tlast;
  logic                    m_tvalid;
  logic                    m_tready;
  logic [DATA_W-1:0]       m_tdata;
  logic                    m_tlast;
  logic [7:0]              m_tdest;
  logic [3:0]              m_tuser;

  modport master (
    input  s_tvalid, s_tdata, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast, m_tdest, m_tuser
  );

  modport slave (
    output s_tvalid, s_tdata, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast, m_tdest, m_tuser
  );
endinterface

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream master among N_SRC sources.
// Datapath is a pure mux (no buffering); overlong packets are cut at MAX_BEATS and the tail drained.
module axis_packet_arbiter #(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_packet_arbiter_if.master      bus,
  output logic                       busy,
  output logic [$clog2(N_SRC)-1:0]   cur_src,
  output logic                       err_overlong
);

  localparam int SW = $clog2(N_SRC);
  localparam int CW = $clog2(MAX_BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, PKT, DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_last_grant, w_last_grant_nxt;
  logic [SW-1:0]   r_cur_src, w_cur_src_nxt;
  logic [SW-1:0]   w_grant;
  logic [CW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic            r_first, w_first_nxt;
  logic            r_err, w_err_nxt;
  logic [7:0]      r_dest;

  logic              w_any_req;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_hs;
  logic              w_at_max;

  assign w_sel_valid = bus.s_tvalid[r_cur_src];
  assign w_sel_last  = bus.s_tlast[r_cur_src];
  assign w_sel_data  = bus.s_tdata[int'(r_cur_src)*DATA_W +: DATA_W];
  assign w_any_req   = |bus.s_tvalid;
  assign w_at_max    = (r_beat_cnt == LAST_BEAT);
  assign w_hs        = (r_state == PKT) && w_sel_valid && bus.m_tready;

  // Walk from the farthest candidate to the nearest so the nearest requester after last_grant wins.
  always_comb begin
    w_grant = r_last_grant;
    for (int k = N_SRC; k >= 1; k--) begin
      if (bus.s_tvalid[(int'(r_last_grant) + k) % N_SRC])
        w_grant = SW'((int'(r_last_grant) + k) % N_SRC);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_cur_src_nxt    = r_cur_src;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_first_nxt      = r_first;
    w_err_nxt        = 1'b0;
    bus.s_tready     = '0;
    bus.m_tvalid     = 1'b0;
    bus.m_tdata      = '0;
    bus.m_tlast      = 1'b0;
    bus.m_tdest      = 8'h00;
    bus.m_tuser      = 4'h0;

    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt    = PKT;
          w_cur_src_nxt  = w_grant;
          w_beat_cnt_nxt = '0;
          w_first_nxt    = 1'b1;
        end
      end

      PKT: begin
        bus.m_tvalid            = w_sel_valid;
        bus.m_tdata             = w_sel_data;
        bus.m_tlast             = w_sel_last | w_at_max;
        bus.m_tdest             = r_first ? w_sel_data[DATA_W-1 -: 8] : r_dest;
        bus.m_tuser             = {3'b000, r_first};
        bus.s_tready[r_cur_src] = bus.m_tready;
        if (w_hs) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          w_first_nxt    = 1'b0;
          if (w_sel_last) begin
            w_state_nxt      = IDLE;
            w_last_grant_nxt = r_cur_src;
          end else if (w_at_max) begin
            w_state_nxt      = DRAIN;
            w_last_grant_nxt = r_cur_src;
            w_err_nxt        = 1'b1;
          end
        end
      end

      DRAIN: begin
        // Swallow the rest of the truncated packet so the source can finish it.
        bus.s_tready[r_cur_src] = 1'b1;
        if (w_sel_valid && w_sel_last)
          w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= SW'(N_SRC - 1);
      r_cur_src    <= '0;
      r_beat_cnt   <= '0;
      r_first      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cur_src    <= w_cur_src_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_first      <= w_first_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // TDEST holder: only meaningful after the first beat, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_hs && r_first)
      r_dest <= w_sel_data[DATA_W-1 -: 8];
  end

  assign busy         = (r_state != IDLE);
  assign cur_src      = r_cur_src;
  assign err_overlong = r_err;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: per-source beat queues feed the DUT, a monitor collects
// the master stream and grant order, and each directed test compares against hand-computed values.
module tb_axis_packet_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic       err_overlong;
  logic [1:0] cur_src;

  always #5 clk = ~clk;

  axis_packet_arbiter_if #(.N_SRC(N), .DATA_W(DW)) bus ();

  axis_packet_arbiter #(.N_SRC(N), .DATA_W(DW), .MAX_BEATS(MB)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .cur_src      (cur_src),
    .err_overlong (err_overlong)
  );

  logic [32:0] smem [N][64];
  int          shead [N];
  int          stail [N];

  logic [31:0] o_data [$];
  logic        o_last [$];
  logic [7:0]  o_dest [$];
  logic [3:0]  o_user [$];
  int          grants [$];
  int          n_err;
  logic        prev_busy;
  logic        tog;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [31:0] d, input logic l);
    smem[s][stail[s]] = {l, d};
    stail[s]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (shead[i] < stail[i]) begin
        bus.s_tvalid[i]          = 1'b1;
        bus.s_tdata[i*DW +: DW]  = smem[i][shead[i]][31:0];
        bus.s_tlast[i]           = smem[i][shead[i]][32];
      end else begin
        bus.s_tvalid[i]          = 1'b0;
        bus.s_tdata[i*DW +: DW]  = '0;
        bus.s_tlast[i]           = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] pop;
    @(negedge clk);
    if (bus.m_tvalid && bus.m_tready) begin
      o_data.push_back(bus.m_tdata);
      o_last.push_back(bus.m_tlast);
      o_dest.push_back(bus.m_tdest);
      o_user.push_back(bus.m_tuser);
    end
    if (err_overlong) n_err++;
    if (busy && !prev_busy) grants.push_back(int'(cur_src));
    prev_busy = busy;
    pop = bus.s_tvalid & bus.s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (pop[i]) shead[i]++;
    if (tog) bus.m_tready = ~bus.m_tready;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_mon();
    o_data.delete();
    o_last.delete();
    o_dest.delete();
    o_user.delete();
    grants.delete();
    n_err = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    prev_busy = 1'b0;
  endtask

  initial begin
    bus.m_tready = 1'b1;
    tog          = 1'b0;
    prev_busy    = 1'b0;
    n_err        = 0;
    for (int i = 0; i < N; i++) begin
      shead[i] = 0;
      stail[i] = 0;
    end
    drive();

    // Test 1: reset values, then a single-beat packet from src0
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", bus.m_tvalid, 0);
    chk("rst_m_tlast",  bus.m_tlast, 0);
    chk("rst_m_tdest",  bus.m_tdest, 0);
    chk("rst_m_tuser",  bus.m_tuser, 0);
    chk("rst_s_tready", bus.s_tready, 0);
    chk("rst_busy",     busy, 0);
    chk("rst_cur_src",  cur_src, 0);
    chk("rst_err",      err_overlong, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
    push(0, 32'hAB001122, 1'b1);
    drive();
    cycle();
    chk("t1_bubble_no_valid", (o_data.size() == 0), 1);
    run(5);
    chk("t1_count", o_data.size(), 1);
    chk("t1_data",  o_data[0], 32'hAB001122);
    chk("t1_dest",  o_dest[0], 8'hAB);
    chk("t1_user",  o_user[0], 4'h1);
    chk("t1_last",  o_last[0], 1);
    chk("t1_grant", grants[0], 0);

    // Test 2: all four sources request two 4-beat packets each; expect strict rotation
    do_reset(2);
    clear_mon();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++)
        for (int b = 0; b < 4; b++)
          push(i, {8'(16 + i), 8'h00, 8'(p), 8'(b)}, b == 3);
    drive();
    run(50);
    chk("t2_count",  o_data.size(), 32);
    chk("t2_ngrant", grants.size(), 8);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("t2_grant%0d", n), grants[n], n % 4);
      for (int b = 0; b < 4; b++) begin
        chk($sformatf("t2_data%0d", n*4+b), o_data[n*4+b], {8'(16 + n % 4), 8'h00, 8'(n / 4), 8'(b)});
        chk($sformatf("t2_dest%0d", n*4+b), o_dest[n*4+b], 8'(16 + n % 4));
        chk($sformatf("t2_user%0d", n*4+b), o_user[n*4+b], (b == 0) ? 4'h1 : 4'h0);
        chk($sformatf("t2_last%0d", n*4+b), o_last[n*4+b], (b == 3));
      end
    end

    // Test 3/6: src2 sends exactly MAX_BEATS beats under toggling backpressure
    clear_mon();
    tog = 1'b1;
    for (int b = 0; b < 8; b++)
      push(2, {8'(8'h5A + b), 8'h33, 8'h00, 8'(b)}, b == 7);
    drive();
    run(30);
    tog = 1'b0;
    bus.m_tready = 1'b1;
    chk("t3_count", o_data.size(), 8);
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("t3_data%0d", b), o_data[b], {8'(8'h5A + b), 8'h33, 8'h00, 8'(b)});
      chk($sformatf("t3_dest%0d", b), o_dest[b], 8'h5A);
      chk($sformatf("t3_user%0d", b), o_user[b], (b == 0) ? 4'h1 : 4'h0);
      chk($sformatf("t3_last%0d", b), o_last[b], (b == 7));
    end
    chk("t6_no_err",   n_err, 0);
    chk("t6_idle",     busy, 0);
    chk("t3_grant",    grants[0], 2);
    chk("t6_consumed", shead[2], stail[2]);

    // Test 4: src1 sends 11 beats, truncated at 8; src2 waits with one beat
    clear_mon();
    for (int b = 0; b < 11; b++)
      push(1, {8'h71, 8'h00, 8'h00, 8'(b)}, b == 10);
    push(2, 32'h220000EE, 1'b1);
    drive();
    run(30);
    chk("t4_count", o_data.size(), 9);
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("t4_data%0d", b), o_data[b], {8'h71, 8'h00, 8'h00, 8'(b)});
      chk($sformatf("t4_last%0d", b), o_last[b], (b == 7));
      chk($sformatf("t4_user%0d", b), o_user[b], (b == 0) ? 4'h1 : 4'h0);
    end
    chk("t4_next_data", o_data[8], 32'h220000EE);
    chk("t4_next_dest", o_dest[8], 8'h22);
    chk("t4_next_last", o_last[8], 1);
    chk("t4_err_cycles", n_err, 1);
    chk("t4_grant0", grants[0], 1);
    chk("t4_grant1", grants[1], 2);
    chk("t4_drained", shead[1], stail[1]);

    // Test 5: reset in the middle of a src3 packet, src0 must win afterwards
    clear_mon();
    for (int b = 0; b < 6; b++)
      push(3, {8'h33, 8'h00, 8'h00, 8'(b)}, b == 5);
    drive();
    for (int c = 0; c < 20 && o_data.size() < 3; c++) cycle();
    chk("t5_reached_beat3", o_data.size(), 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_rst_s_tready", bus.s_tready, 0);
    chk("t5_rst_m_tvalid", bus.m_tvalid, 0);
    chk("t5_rst_busy",     busy, 0);
    chk("t5_rst_cur_src",  cur_src, 0);
    chk("t5_rst_m_tuser",  bus.m_tuser, 0);
    rst = 1'b0;
    prev_busy = 1'b0;
    clear_mon();
    push(0, 32'h0A000001, 1'b1);
    drive();
    run(20);
    chk("t5_grant0",   grants[0], 0);
    chk("t5_grant1",   grants[1], 3);
    chk("t5_src0_data", o_data[0], 32'h0A000001);
    chk("t5_src3_data", o_data[1], 32'h33000003);
    chk("t5_src3_user", o_user[1], 4'h1);
    chk("t5_count",     o_data.size(), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
